// File: rtl/patch_loader_pkg.sv
// Shared definitions for the patch loader: FSM state encoding and FIFO depth.
package patch_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Depth of the input skid FIFO between the aggregator and the memory port.
  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/patch_loader_fifo.sv
// Two-entry FIFO buffering aggregated words ahead of the memory write port.
// Push on full and pop on empty are ignored; push and pop in the same cycle
// are both honoured whenever the FIFO is neither full (push) nor empty (pop).
module patch_loader_fifo
  import patch_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; storage clears so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/patch_loader.sv
// Patch loader: accepts num_words aggregated words from the upstream aggregator
// and writes them in order to consecutive memory addresses starting at base_addr.
// Optional feature macro: PATCH_LOADER_CHECKSUM_EN adds a lane-XOR checksum output.
//
// Handshakes: an input word transfers on a cycle where in_enq && in_full_n;
// a memory write transfers on a cycle where mem_wen is high (mem_wen already
// includes mem_ready). in_full_n and mem_wen never depend on in_enq.
module patch_loader
  import patch_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FETCH_WIDTH = 40,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                              in_enq,
  output logic                              in_full_n,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [ADDR_WIDTH-1:0]             num_words,
  input  logic                              mem_ready,
  output logic                              mem_wen,
  output logic [ADDR_WIDTH-1:0]             mem_waddr,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] mem_wdata,
  output logic                              busy,
  output logic                              done,
`ifdef PATCH_LOADER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]             checksum,
`endif
  output state_t                            dbg_state
);

  localparam int WORD_W = FETCH_WIDTH * DATA_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] num_q, num_d;
  logic [ADDR_WIDTH-1:0] acc_q, acc_d;   // words accepted from upstream
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;     // words written to memory

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              push;
  logic              pop;

  // Accept only while loading, with room, and before the requested count is reached.
  assign in_full_n = (state_q == ST_LOAD) && !fifo_full && (acc_q < num_q);
  assign push      = in_enq && in_full_n;
  assign mem_wen   = (state_q == ST_LOAD) && !fifo_empty && mem_ready;
  assign pop       = mem_wen;
  assign mem_wdata = fifo_head;
  assign mem_waddr = base_q + wr_q;   // wraps modulo 2^ADDR_WIDTH
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

  patch_loader_fifo #(
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_data),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State and load-context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic: latch the request, count transfers, finish on the last write.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          num_d   = num_words;
          acc_d   = '0;
          wr_d    = '0;
          state_d = (num_words == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (push) acc_d = acc_q + ADDR_WIDTH'(1);
        if (pop) begin
          wr_d = wr_q + ADDR_WIDTH'(1);
          if (wr_q == num_q - ADDR_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PATCH_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  function automatic logic [DATA_WIDTH-1:0] lane_xor(input logic [WORD_W-1:0] w);
    logic [DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) acc = acc ^ w[i*DATA_WIDTH +: DATA_WIDTH];
    return acc;
  endfunction

  // Running XOR of every lane written; cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      csum_q <= '0;
    end else if (mem_wen) begin
      csum_q <= csum_q ^ lane_xor(mem_wdata);
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: doc/patch_loader.md
PATCH_LOADER -- requirements
Module: patch_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one patch element.
REQ-002 SHALL have parameter FETCH_WIDTH, default 40, elements per aggregated word.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_data  input  FETCH_WIDTH*DATA_WIDTH  aggregated word from the upstream aggregator.
REQ-007 SHALL have port in_enq  input  1  in_data valid this cycle.
REQ-008 SHALL have port in_full_n  output  1  high when an in_enq is accepted this cycle.
REQ-009 SHALL have port start  input  1  one-cycle load request.
REQ-010 SHALL have port base_addr  input  ADDR_WIDTH  first write address, sampled on start.
REQ-011 SHALL have port num_words  input  ADDR_WIDTH  words to load, sampled on start.
REQ-012 SHALL have port mem_ready  input  1  memory accepts a write this cycle.
REQ-013 SHALL have ports mem_wen  output  1, mem_waddr  output  ADDR_WIDTH, and mem_wdata  output  FETCH_WIDTH*DATA_WIDTH: the memory write port.
REQ-014 SHALL have ports busy  output  1 (high in LOAD) and done  output  1 (one-cycle pulse at load completion).

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> DONE -> IDLE.
REQ-016 In IDLE, start with num_words != 0 SHALL latch base_addr/num_words, clear counters, and go to LOAD next cycle.
REQ-017 In IDLE, start with num_words == 0 SHALL go directly to DONE; no writes.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 SHALL buffer input words in a 2-entry FIFO; in_full_n = (state==LOAD) && FIFO not full && accepted count < num_words.
REQ-020 in_enq while in_full_n low SHALL be dropped without a state change.
REQ-021 mem_wen SHALL be high iff state==LOAD && FIFO non-empty && mem_ready; each such cycle pops one word.
REQ-022 mem_wdata SHALL be the FIFO head; mem_waddr = base_addr + written count, modulo 2^ADDR_WIDTH (wraps silently).
REQ-023 Simultaneous push and pop on a full FIFO SHALL NOT be allowed (in_full_n low); on a 1-entry FIFO both SHALL complete in the same cycle.
REQ-024 Minimum latency: a word accepted in cycle N SHALL appear on mem_wen in cycle N+1 if mem_ready.
REQ-025 After the write with written count == num_words-1, SHALL enter DONE; done high for exactly that one cycle; then IDLE.
REQ-026 Word ordering SHALL be preserved: the k-th accepted word is written to base_addr+k.

Reset
REQ-027 rst_n low at a clock edge SHALL force IDLE, empty the FIFO, clear counters; mem_wen=0, in_full_n=0, busy=0, done=0 at the next cycle, including mid-LOAD.
REQ-028 mem_waddr and mem_wdata SHALL reset to 0.

Configuration
REQ-029 With macro PATCH_LOADER_CHECKSUM_EN defined, SHALL add output checksum[DATA_WIDTH-1:0] = XOR of all DATA_WIDTH lanes of all written words, cleared on start, valid while done is high.
REQ-030 Without PATCH_LOADER_CHECKSUM_EN, port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (IDLE=0, LOAD=1, DONE=2) and the FIFO depth constant (2).
REQ-032 The FIFO SHALL be a separate sub-module named patch_loader_fifo (2-entry, width-parameterised, push/pop/full/empty).

Verification
REQ-033 start, base_addr=0x10, num_words=3, three back-to-back enqs, mem_ready=1 -> writes at 0x10,0x11,0x12 in order; done pulse once; busy low after.
REQ-034 num_words=0 start -> done the cycle after, mem_wen never high, in_full_n never high.
REQ-035 num_words=4, mem_ready=0 for 10 cycles -> in_full_n drops after 2 accepts; no loss once mem_ready=1; 4 ordered writes.
REQ-036 base_addr=0x3FE, num_words=4, ADDR_WIDTH=10 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-037 rst_n low after 2 of 5 writes -> next cycle IDLE, mem_wen=0, no done; new start loads cleanly from count 0.
REQ-038 With PATCH_LOADER_CHECKSUM_EN, two words of all lanes 0x0001 then 0x0003 (FETCH_WIDTH=40) -> checksum 0x0000 at done; with lane 0 only 0x00FF in one word, rest 0 -> 0x00FF.
